// File: rtl/usb_mem_port_arb_if.sv
// usb_mem_port_arb_if: requester, descriptor-memory port-B and collision signals of the arbiter
interface usb_mem_port_arb_if #(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int MEM_NUM_COL = 4,
  parameter int MEM_COL_WIDTH = 32
);
  logic a_req, a_gnt, a_rvalid, h_req, h_gnt, h_rvalid, En_B, col_err;
  logic [MEM_ADDR_WIDTH-1:0] a_addr, h_addr, addrB;
  logic [MEM_NUM_COL-1:0] a_wen, a_ren, h_wen, h_ren, w_B, r_B;
  logic [MEM_COL_WIDTH-1:0] a_wdata, a_rdata, h_wdata, h_rdata, dinB, doutB;
  modport slave (
    input a_req, a_addr, a_wen, a_ren, a_wdata, h_req, h_addr, h_wen, h_ren, h_wdata, doutB,
    output a_gnt, a_rdata, a_rvalid, h_gnt, h_rdata, h_rvalid, En_B, w_B, r_B, addrB, dinB, col_err
  );
  modport master (
    output a_req, a_addr, a_wen, a_ren, a_wdata, h_req, h_addr, h_wen, h_ren, h_wdata, doutB,
    input a_gnt, a_rdata, a_rvalid, h_gnt, h_rdata, h_rvalid, En_B, w_B, r_B, addrB, dinB, col_err
  );
endinterface

// File: rtl/usb_mem_port_arb.sv
// usb_mem_port_arb: AXI-side / host-engine arbiter for descriptor memory port B (USB_ARB_HOST_PRIO_EN: strict host priority)
module usb_mem_port_arb #(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int MEM_NUM_COL = 4,
  parameter int MEM_COL_WIDTH = 32,
  parameter int MAX_BURST = 4
) (
  input logic UHCI_clk,
  input logic Rst,
  usb_mem_port_arb_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_H} state_t;
  state_t state, nxt;
  logic [CW-1:0] beat_cnt;
  logic last_h, a_gnt, h_gnt, a_rv, h_rv, acc_a, acc_h, coll;
  logic [MEM_ADDR_WIDTH-1:0] addr_s;
  logic [MEM_NUM_COL-1:0] wen_s, ren_s;
  logic [MEM_COL_WIDTH-1:0] din_s;
  always_comb begin
    acc_a = state == GNT_A && bus.a_req;
    acc_h = state == GNT_H && bus.h_req;
    addr_s = acc_a ? bus.a_addr : acc_h ? bus.h_addr : '0;
    wen_s = acc_a ? bus.a_wen : acc_h ? bus.h_wen : '0;
    ren_s = acc_a ? bus.a_ren : acc_h ? bus.h_ren : '0;
    din_s = acc_a ? bus.a_wdata : acc_h ? bus.h_wdata : '0;
    coll = |wen_s && |ren_s;
  end
`ifdef USB_ARB_HOST_PRIO_EN
  // a pending host request always wins, which also preempts A after its current beat
  always_comb nxt = bus.h_req ? GNT_H : bus.a_req ? GNT_A : IDLE;
`else
  logic burst_done;
  always_comb begin
    burst_done = beat_cnt >= CW'(MAX_BURST - 1);
    case (state)
      GNT_A: nxt = !bus.a_req ? (bus.h_req ? GNT_H : IDLE) : (bus.h_req && burst_done) ? GNT_H : GNT_A;
      GNT_H: nxt = !bus.h_req ? (bus.a_req ? GNT_A : IDLE) : (bus.a_req && burst_done) ? GNT_A : GNT_H;
      default: nxt = (bus.a_req && bus.h_req) ? (last_h ? GNT_A : GNT_H) : bus.a_req ? GNT_A : bus.h_req ? GNT_H : IDLE;
    endcase
  end
`endif
  always_ff @(posedge UHCI_clk) begin
    if (Rst) begin
      state <= IDLE;
      a_gnt <= 1'b0;
      h_gnt <= 1'b0;
      a_rv <= 1'b0;
      h_rv <= 1'b0;
      beat_cnt <= '0;
      last_h <= 1'b0;
    end else begin
      state <= nxt;
      a_gnt <= nxt == GNT_A;
      h_gnt <= nxt == GNT_H;
      a_rv <= acc_a && !coll && |ren_s;
      h_rv <= acc_h && !coll && |ren_s;
      beat_cnt <= nxt != state ? '0 : ((acc_a || acc_h) && beat_cnt != CW'(MAX_BURST)) ? beat_cnt + 1'b1 : beat_cnt;
      last_h <= nxt == GNT_H ? 1'b1 : nxt == GNT_A ? 1'b0 : last_h;
    end
  end
  assign bus.a_gnt = a_gnt;
  assign bus.h_gnt = h_gnt;
  assign bus.En_B = acc_a || acc_h;
  assign bus.w_B = wen_s;
  assign bus.r_B = coll ? '0 : ren_s;
  assign bus.addrB = addr_s;
  assign bus.dinB = din_s;
  assign bus.col_err = coll;
  assign bus.a_rvalid = a_rv;
  assign bus.h_rvalid = h_rv;
  assign bus.a_rdata = a_rv ? bus.doutB : '0;
  assign bus.h_rdata = h_rv ? bus.doutB : '0;
endmodule

// File: tb/tb_usb_mem_port_arb.sv
// tb_usb_mem_port_arb: directed table, corner sequences and randomized run against a behavioural arbitration model
module tb_usb_mem_port_arb;
  localparam int MB = 4;
  logic UHCI_clk = 1'b0;
  logic Rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  string phase = "reset";
  logic [31:0] mem [64];
  logic [31:0] rmem [64];
  int own, last, beats, nxt_own;
  logic mrv_a, mrv_h, ma, mh, ra, rh, e_col;
  logic [31:0] mrd, awd, hwd, e_wd;
  logic [5:0] aad, had, e_ad;
  logic [3:0] awe, are, hwe, hre, e_we, e_re, e_rb;

  typedef struct {
    logic a, h;
    logic [5:0] ad;
    logic [3:0] we, re;
    logic [31:0] wd;
    logic ag, hg, en;
    logic [3:0] w, r;
    logic [5:0] ma;
    logic [31:0] din;
    logic col, arv, hrv;
    logic [31:0] ard, hrd;
  } vec_t;
  vec_t tbl [13];

  usb_mem_port_arb_if #(.MEM_ADDR_WIDTH(6), .MEM_NUM_COL(4), .MEM_COL_WIDTH(32)) bus ();
  usb_mem_port_arb #(.MEM_ADDR_WIDTH(6), .MEM_NUM_COL(4), .MEM_COL_WIDTH(32), .MAX_BURST(MB))
    dut (.UHCI_clk(UHCI_clk), .Rst(Rst), .bus(bus));

  always #5 UHCI_clk = ~UHCI_clk;

  // registered descriptor memory with byte-lane writes and one-cycle read latency
  always @(posedge UHCI_clk) begin
    if (Rst) for (int i = 0; i < 64; i++) mem[i] <= '0;
    else if (bus.En_B) for (int i = 0; i < 4; i++) if (bus.w_B[i]) mem[bus.addrB][8*i +: 8] <= bus.dinB[8*i +: 8];
    if (bus.En_B && |bus.r_B) bus.doutB <= mem[bus.addrB];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s cycle %0d got %0h expected %0h", phase, nm, cyc, act, exp);
    end
  endtask

  task automatic expect_outs(input logic ag, hg, en, input logic [3:0] w, r, input logic [5:0] ad,
                             input logic [31:0] din, input logic col, arv, hrv, input logic [31:0] ard, hrd);
    chk("a_gnt", 32'(bus.a_gnt), 32'(ag));
    chk("h_gnt", 32'(bus.h_gnt), 32'(hg));
    chk("En_B", 32'(bus.En_B), 32'(en));
    chk("w_B", 32'(bus.w_B), 32'(w));
    chk("r_B", 32'(bus.r_B), 32'(r));
    chk("addrB", 32'(bus.addrB), 32'(ad));
    chk("dinB", bus.dinB, din);
    chk("col_err", 32'(bus.col_err), 32'(col));
    chk("a_rvalid", 32'(bus.a_rvalid), 32'(arv));
    chk("h_rvalid", 32'(bus.h_rvalid), 32'(hrv));
    chk("a_rdata", bus.a_rdata, ard);
    chk("h_rdata", bus.h_rdata, hrd);
  endtask

  task automatic set_a(input logic r, input logic [5:0] ad, input logic [3:0] we, re, input logic [31:0] wd);
    bus.a_req = r; bus.a_addr = ad; bus.a_wen = we; bus.a_ren = re; bus.a_wdata = wd;
  endtask

  task automatic set_h(input logic r, input logic [5:0] ad, input logic [3:0] we, re, input logic [31:0] wd);
    bus.h_req = r; bus.h_addr = ad; bus.h_wen = we; bus.h_ren = re; bus.h_wdata = wd;
  endtask

  task automatic step();
    @(posedge UHCI_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    set_a(1'b0, 6'd0, 4'h0, 4'h0, 32'h0);
    set_h(1'b0, 6'd0, 4'h0, 4'h0, 32'h0);
    repeat (2) @(posedge UHCI_clk);
    #1;
    Rst = 1'b0;
    cyc = 0;
  endtask

  task automatic gnts(input logic ag, hg);
    @(negedge UHCI_clk);
    chk("a_gnt", 32'(bus.a_gnt), 32'(ag));
    chk("h_gnt", 32'(bus.h_gnt), 32'(hg));
  endtask

  task automatic rnd_op(output logic [3:0] we, re);
    int k;
    k = $urandom_range(0, 4);
    we = (k == 0 || k == 3) ? 4'($urandom) : 4'h0;
    re = (k == 1) ? 4'hF : (k == 2 || k == 3) ? 4'($urandom) : 4'h0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 6'd5, 4'hF, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 6'd5, 4'hF, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 6'd5, 4'h0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 6'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 6'd0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 6'd6, 4'h1, 4'h2, 32'h11223344, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 6'd6, 4'h1, 4'h2, 32'h11223344, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0, 6'd6, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 6'd0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 6'd5, 4'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 6'd5, 4'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 6'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 6'd7, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 1'b0, 6'd7, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 6'd7, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 6'd0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 6'd0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    set_a(1'b0, 6'd0, 4'h0, 4'h0, 32'h0);
    set_h(1'b0, 6'd0, 4'h0, 4'h0, 32'h0);
    repeat (3) @(posedge UHCI_clk);
    @(negedge UHCI_clk);
    expect_outs(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge UHCI_clk);
    #1;
    Rst = 1'b0;

    phase = "table";
    cyc = 0;
    foreach (tbl[i]) begin
      set_a(tbl[i].a, tbl[i].ad, tbl[i].we, tbl[i].re, tbl[i].wd);
      set_h(tbl[i].h, tbl[i].ad, tbl[i].we, tbl[i].re, tbl[i].wd);
      @(negedge UHCI_clk);
      expect_outs(tbl[i].ag, tbl[i].hg, tbl[i].en, tbl[i].w, tbl[i].r, tbl[i].ma, tbl[i].din,
                  tbl[i].col, tbl[i].arv, tbl[i].hrv, tbl[i].ard, tbl[i].hrd);
      step();
    end

`ifndef USB_ARB_HOST_PRIO_EN
    phase = "rr_burst";
    do_reset();
    set_a(1'b1, 6'd3, 4'h0, 4'h0, 32'h0);
    set_h(1'b1, 6'd9, 4'hF, 4'h0, 32'hCAFEF00D);
    gnts(1'b0, 1'b0);
    step();
    gnts(1'b0, 1'b1);
    chk("w_B", 32'(bus.w_B), 32'hF);
    chk("addrB", 32'(bus.addrB), 32'd9);
    step();
    set_h(1'b1, 6'd9, 4'h0, 4'h0, 32'h0);
    gnts(1'b0, 1'b1);
    step();
    gnts(1'b0, 1'b1);
    step();
    set_h(1'b1, 6'd9, 4'h0, 4'hF, 32'h0);
    gnts(1'b0, 1'b1);
    chk("r_B", 32'(bus.r_B), 32'hF);
    step();
    set_h(1'b1, 6'd9, 4'h0, 4'h0, 32'h0);
    gnts(1'b1, 1'b0);
    chk("h_rvalid", 32'(bus.h_rvalid), 32'd1);
    chk("h_rdata", bus.h_rdata, 32'hCAFEF00D);
    chk("a_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("addrB", 32'(bus.addrB), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      gnts(1'b1, 1'b0);
    end
    step();
    gnts(1'b0, 1'b1);
`else
    phase = "prio_preempt";
    do_reset();
    set_a(1'b1, 6'd4, 4'h0, 4'h0, 32'h0);
    gnts(1'b0, 1'b0);
    step();
    gnts(1'b1, 1'b0);
    step();
    set_h(1'b1, 6'd4, 4'h0, 4'h0, 32'h0);
    gnts(1'b1, 1'b0);
    chk("En_B", 32'(bus.En_B), 32'd1);
    step();
    gnts(1'b0, 1'b1);
    step();
    gnts(1'b0, 1'b1);
    step();
    set_h(1'b0, 6'd4, 4'h0, 4'h0, 32'h0);
    gnts(1'b0, 1'b1);
    chk("En_B", 32'(bus.En_B), 32'd0);
    step();
    gnts(1'b1, 1'b0);
`endif

    phase = "rst_mid_burst";
    do_reset();
    set_a(1'b1, 6'd9, 4'h0, 4'hF, 32'h0);
    gnts(1'b0, 1'b0);
    step();
    gnts(1'b1, 1'b0);
    chk("r_B", 32'(bus.r_B), 32'hF);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    set_a(1'b0, 6'd0, 4'h0, 4'h0, 32'h0);
    gnts(1'b0, 1'b0);
    chk("a_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("a_rdata", bus.a_rdata, 32'h0);
    step();
    gnts(1'b0, 1'b0);
    chk("a_rvalid", 32'(bus.a_rvalid), 32'd0);

    phase = "random";
    do_reset();
    for (int i = 0; i < 64; i++) rmem[i] = '0;
    own = 0; last = 1; beats = 0; mrv_a = 1'b0; mrv_h = 1'b0; mrd = '0;
    for (int n = 0; n < 3000; n++) begin
      ra = $urandom_range(0, 3) != 0;
      rh = $urandom_range(0, 3) != 0;
      aad = 6'($urandom_range(0, 7));
      had = 6'($urandom_range(0, 7));
      rnd_op(awe, are);
      rnd_op(hwe, hre);
      awd = $urandom;
      hwd = $urandom;
      set_a(ra, aad, awe, are, awd);
      set_h(rh, had, hwe, hre, hwd);
      @(negedge UHCI_clk);
      ma = own == 1 && ra;
      mh = own == 2 && rh;
      e_ad = ma ? aad : mh ? had : 6'd0;
      e_we = ma ? awe : mh ? hwe : 4'h0;
      e_re = ma ? are : mh ? hre : 4'h0;
      e_wd = ma ? awd : mh ? hwd : 32'h0;
      e_col = e_we != 0 && e_re != 0;
      e_rb = e_col ? 4'h0 : e_re;
      expect_outs(own == 1, own == 2, ma || mh, e_we, e_rb, e_ad, e_wd, e_col,
                  mrv_a, mrv_h, mrv_a ? mrd : 32'h0, mrv_h ? mrd : 32'h0);
      mrv_a = ma && e_rb != 0;
      mrv_h = mh && e_rb != 0;
      if (e_rb != 0) mrd = rmem[e_ad];
      for (int b = 0; b < 4; b++) if (e_we[b]) rmem[e_ad][8*b +: 8] = e_wd[8*b +: 8];
`ifdef USB_ARB_HOST_PRIO_EN
      nxt_own = rh ? 2 : ra ? 1 : 0;
`else
      if (own == 0) nxt_own = (ra && rh) ? 3 - last : ra ? 1 : rh ? 2 : 0;
      else if (!(own == 1 ? ra : rh)) nxt_own = (own == 1 ? rh : ra) ? 3 - own : 0;
      else nxt_own = ((own == 1 ? rh : ra) && beats + 1 >= MB) ? 3 - own : own;
`endif
      beats = nxt_own != own ? 0 : (ma || mh) ? beats + 1 : beats;
      if (nxt_own != 0) last = nxt_own;
      own = nxt_own;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
